// File: rtl/vga_console_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_console_pkg
// Description : Shared constants for the VGA text-console character fetcher:
//               default console geometry and the fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_console_pkg;

    // Default console geometry (80x25 text, 8x16 glyph cells)
    localparam int c_def_cols      = 80;
    localparam int c_def_rows      = 25;
    localparam int c_def_char_bits = 8;
    localparam int c_def_glyph_h   = 16;

    // Fetch FSM state encoding
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t c_st_idle  = 2'd0;
    localparam fsm_state_t c_st_fetch = 2'd1;
    localparam fsm_state_t c_st_drain = 2'd2;

endpackage
`default_nettype wire

// File: rtl/vga_console_char_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_console_char_fetch_if
// Description : Bus bundle between the pixel pipeline / char RAM and the
//               character fetcher. Signal directions are named from the
//               fetcher's point of view (i_ = into fetcher, o_ = out of it).
//   i_line_req   line prefetch request pulse (hblank start)
//   i_line_y     upcoming pixel line index
//   o_ram_addr   char RAM read address
//   i_ram_char   char RAM read data (1-cycle latency)
//   i_col        column requested by the pixel pipeline
//   o_char_out   buffered character for i_col (registered)
//   o_glyph_row  pixel row inside the glyph cell
//   o_line_ready buffer holds the current text row
//   o_busy       fetch in progress
//   o_overrun    sticky: request arrived while busy
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_console_char_fetch_if #(
    parameter int COLS      = vga_console_pkg::c_def_cols,
    parameter int ROWS      = vga_console_pkg::c_def_rows,
    parameter int CHAR_BITS = vga_console_pkg::c_def_char_bits,
    parameter int GLYPH_H   = vga_console_pkg::c_def_glyph_h
);
    localparam int ADDR_W = $clog2(COLS * ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int Y_W    = $clog2(ROWS * GLYPH_H);
    localparam int GR_W   = $clog2(GLYPH_H);

    logic                 i_line_req;
    logic [Y_W-1:0]       i_line_y;
    logic [ADDR_W-1:0]    o_ram_addr;
    logic [CHAR_BITS-1:0] i_ram_char;
    logic [COL_W-1:0]     i_col;
    logic [CHAR_BITS-1:0] o_char_out;
    logic [GR_W-1:0]      o_glyph_row;
    logic                 o_line_ready;
    logic                 o_busy;
    logic                 o_overrun;

    // Fetcher side
    modport slave (
        input  i_line_req, i_line_y, i_ram_char, i_col,
        output o_ram_addr, o_char_out, o_glyph_row, o_line_ready, o_busy, o_overrun
    );

    // Pixel pipeline / RAM side
    modport master (
        output i_line_req, i_line_y, i_ram_char, i_col,
        input  o_ram_addr, o_char_out, o_glyph_row, o_line_ready, o_busy, o_overrun
    );

endinterface
`default_nettype wire

// File: rtl/vga_console_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : vga_console_line_buf
// Description : One text row of characters, COLS x CHAR_BITS, simple
//               dual-port: one write port, one registered read port.
//               Read and write of the same entry in the same cycle returns
//               the old contents. Out-of-range read addresses return 0.
//   vga_clk / reset_n   clock, async active-low reset (read register only)
//   i_wr_en/addr/data   write port
//   i_rd_addr           read address
//   o_rd_data           registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module vga_console_line_buf #(
    parameter int COLS      = 80,
    parameter int CHAR_BITS = 8,
    parameter int COL_W     = $clog2(COLS)
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    input  logic                 i_wr_en,
    input  logic [COL_W-1:0]     i_wr_addr,
    input  logic [CHAR_BITS-1:0] i_wr_data,
    input  logic [COL_W-1:0]     i_rd_addr,
    output logic [CHAR_BITS-1:0] o_rd_data
);
    localparam logic [COL_W-1:0] c_last_col = COL_W'(COLS - 1);

    logic [CHAR_BITS-1:0] r_mem [COLS];
    logic [CHAR_BITS-1:0] r_rd_data;

    // Storage carries no reset: contents after reset are don't-care.
    always_ff @(posedge vga_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (i_rd_addr <= c_last_col) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/vga_console_char_fetch.sv
`default_nettype none
// ============================================================================
// Module      : vga_console_char_fetch
// Description : Prefetches one text row of characters from the char RAM into
//               a line buffer during hblank, then serves the pixel pipeline
//               column by column from that buffer.
//   vga_clk  pixel clock (rising edge)
//   reset_n  asynchronous active-low reset
//   bus      vga_console_char_fetch_if.slave (see interface for signals)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_console_char_fetch #(
    parameter int COLS      = vga_console_pkg::c_def_cols,
    parameter int ROWS      = vga_console_pkg::c_def_rows,
    parameter int CHAR_BITS = vga_console_pkg::c_def_char_bits,
    parameter int GLYPH_H   = vga_console_pkg::c_def_glyph_h
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    vga_console_char_fetch_if.slave   bus
);
    import vga_console_pkg::*;

    localparam int ADDR_W = $clog2(COLS * ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int Y_W    = $clog2(ROWS * GLYPH_H);
    localparam int GR_W   = $clog2(GLYPH_H);

    localparam logic [Y_W:0]     c_y_lim    = (Y_W + 1)'(ROWS * GLYPH_H);
    localparam logic [COL_W-1:0] c_last_col = COL_W'(COLS - 1);

    fsm_state_t           r_state;
    logic [ADDR_W-1:0]    r_ram_addr;
    logic [COL_W-1:0]     r_k;          // column currently being addressed
    logic                 r_wr_en;      // RAM data for r_wr_idx is on i_ram_char
    logic [COL_W-1:0]     r_wr_idx;
    logic [GR_W-1:0]      r_glyph_row;
    logic                 r_line_ready;
    logic                 r_overrun;
    logic                 r_last_valid;
    logic [Y_W-1:0]       r_last_row;
    logic [Y_W-1:0]       r_row;        // row of the fetch in flight
    logic [CHAR_BITS-1:0] w_char_out;

    logic [Y_W-1:0]       w_row;
    logic                 w_in_range;
    logic                 w_hit;
    logic [ADDR_W-1:0]    w_base;

    assign w_row      = bus.i_line_y >> GR_W;
    assign w_in_range = ({1'b0, bus.i_line_y} < c_y_lim);
    assign w_hit      = r_last_valid && (w_row == r_last_row);
    // Single multiply per accepted request; the per-column path only increments.
    assign w_base     = ADDR_W'(w_row * COLS);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_st_idle;
            r_ram_addr   <= '0;
            r_k          <= '0;
            r_wr_en      <= 1'b0;
            r_wr_idx     <= '0;
            r_glyph_row  <= '0;
            r_line_ready <= 1'b0;
            r_overrun    <= 1'b0;
            r_last_valid <= 1'b0;
            r_last_row   <= '0;
            r_row        <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.i_line_req) begin
                        r_glyph_row <= bus.i_line_y[GR_W-1:0];
                        if (!w_in_range) begin
                            r_line_ready <= 1'b0;
                        end else if (w_hit) begin
                            r_line_ready <= 1'b1;
                        end else begin
                            r_line_ready <= 1'b0;
                            r_ram_addr   <= w_base;
                            r_k          <= '0;
                            r_row        <= w_row;
                            r_state      <= c_st_fetch;
                        end
                    end
                end
                c_st_fetch: begin
                    // Data for the address issued this cycle lands next cycle.
                    r_wr_en  <= 1'b1;
                    r_wr_idx <= r_k;
                    if (r_k == c_last_col) begin
                        r_state <= c_st_drain;
                    end else begin
                        r_k        <= r_k + COL_W'(1);
                        r_ram_addr <= r_ram_addr + ADDR_W'(1);
                    end
                    if (bus.i_line_req) begin
                        r_overrun <= 1'b1;
                    end
                end
                c_st_drain: begin
                    // Final buffer write happens on this edge.
                    r_state      <= c_st_idle;
                    r_line_ready <= 1'b1;
                    r_last_row   <= r_row;
                    r_last_valid <= 1'b1;
                    if (bus.i_line_req) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    vga_console_line_buf #(
        .COLS      (COLS),
        .CHAR_BITS (CHAR_BITS),
        .COL_W     (COL_W)
    ) u_line_buf (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .i_wr_en   (r_wr_en),
        .i_wr_addr (r_wr_idx),
        .i_wr_data (bus.i_ram_char),
        .i_rd_addr (bus.i_col),
        .o_rd_data (w_char_out)
    );

    assign bus.o_ram_addr   = r_ram_addr;
    assign bus.o_char_out   = w_char_out;
    assign bus.o_glyph_row  = r_glyph_row;
    assign bus.o_line_ready = r_line_ready;
    assign bus.o_busy       = (r_state != c_st_idle);
    assign bus.o_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/vga_console_char_fetch.md
VGA_CONSOLE_CHAR_FETCH -- requirements
Module: vga_console_char_fetch

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 25, text rows; COLS*ROWS equals the character RAM CHAR_COUNT.
REQ-003 Parameter CHAR_BITS, default 8, character width; legal values 8, 16, 32.
REQ-004 Parameter GLYPH_H, default 16, glyph height in pixel lines; power of 2.
REQ-005 Derived widths: ADDR_W=clog2(COLS*ROWS), COL_W=clog2(COLS), Y_W=clog2(ROWS*GLYPH_H), GR_W=clog2(GLYPH_H).
REQ-006 vga_clk  in  1  pixel clock; all logic on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 line_req  in  1  one-cycle pulse requesting prefetch for the upcoming pixel line, issued at hblank start.
REQ-009 line_y  in  Y_W  index of the upcoming pixel line; sampled when line_req=1.
REQ-010 ram_addr  out  ADDR_W  character address to the char RAM read port (vga_char_address).
REQ-011 ram_char  in  CHAR_BITS  char RAM data, valid exactly 1 cycle after ram_addr.
REQ-012 col  in  COL_W  column requested by the pixel pipeline.
REQ-013 char_out  out  CHAR_BITS  buffered character for col, registered.
REQ-014 glyph_row  out  GR_W  line_y mod GLYPH_H, latched on an accepted line_req.
REQ-015 line_ready  out  1  buffer holds the text row for the current line.
REQ-016 busy  out  1  fetch in progress.
REQ-017 overrun  out  1  sticky error flag.

Function
REQ-018 FSM states: IDLE, FETCH, DRAIN; only IDLE accepts line_req.
REQ-019 On line_req in IDLE: row=line_y>>log2(GLYPH_H); base=row*COLS registered; glyph_row updated; line_ready cleared next cycle.
REQ-020 line_y >= ROWS*GLYPH_H: no fetch, state stays IDLE, line_ready=0, buffer and last_row unchanged.
REQ-021 row equal to last fetched row with last_valid=1: no fetch, line_ready=1 on the cycle after line_req.
REQ-022 Otherwise enter FETCH: line_req at cycle T -> ram_addr=base+k at cycle T+1+k, k=0..COLS-1.
REQ-023 ram_char is written into buffer entry k at edge T+2+k; DRAIN covers the final write.
REQ-024 After the last write: state IDLE, busy=0, line_ready=1 at cycle T+COLS+2, last_row=row, last_valid=1.
REQ-025 busy=1 exactly while in FETCH or DRAIN.
REQ-026 ram_addr holds its last value while not fetching; never exceeds COLS*ROWS-1.
REQ-027 char_out = buffer[col] one cycle after col is presented; a simultaneous write to the same entry returns the old data.
REQ-028 col >= COLS: char_out=0.
REQ-029 line_req while busy: ignored (fetch continues unchanged); overrun set and held until reset.
REQ-030 Fetch length COLS+2 cycles must fit in hblank; this is a system constraint, not checked.

Reset
REQ-031 reset_n low: state IDLE, ram_addr=0, char_out=0, glyph_row=0, line_ready=0, busy=0, overrun=0, last_valid=0.
REQ-032 Reset mid-fetch aborts immediately; buffer contents are undefined afterwards; the first post-reset line_req always fetches.

Structure
REQ-033 Package vga_console_pkg holds default COLS/ROWS/GLYPH_H/CHAR_BITS constants and the FSM state encoding.
REQ-034 Sub-module vga_console_line_buf: COLS x CHAR_BITS simple dual-port (1 write, 1 registered read), one per instance.
REQ-035 Multiplication row*COLS is performed once per request, outside the per-column path.

Verification (COLS=80, ROWS=25, GLYPH_H=16, RAM model 1-cycle latency, content = address[7:0])
REQ-036 Reset, line_req with line_y=35 at T -> ram_addr 160..239 on T+1..T+80, line_ready=1 at T+82, glyph_row=3, col=5 gives char_out=0xA5.
REQ-037 Next line_y=36 after completion -> no ram_addr change, line_ready=1 on the following cycle, busy never set.
REQ-038 line_y=399 -> ram_addr 1920..1999, no wrap past 1999; line_y=400 -> no fetch, line_ready=0.
REQ-039 line_req again at T+10 during a fetch -> fetch completes unchanged at T+82, overrun=1 and held.
REQ-040 reset_n low at T+40 of a fetch -> all outputs at reset values; next line_y=35 re-fetches in full.
